// File: rtl/pipez_pkg.sv
// Shared opcodes, ALU encodings, condition-code layout and branch-condition helper
// for the pipez 4-stage core.
package pipez_pkg;

  localparam logic [7:0] OP_IRMOV = 8'h10;
  localparam logic [7:0] OP_HALT  = 8'h11;
  localparam logic [7:0] OP_NOP   = 8'h12;
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_SUB   = 8'h21;
  localparam logic [7:0] OP_AND   = 8'h22;
  localparam logic [7:0] OP_XOR   = 8'h23;
  localparam logic [7:0] OP_RRMOV = 8'h30;
  localparam logic [7:0] OP_CMOVG = 8'h36;
  localparam logic [7:0] OP_JMP   = 8'h70;
  localparam logic [7:0] OP_JG    = 8'h76;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } run_state_e;

  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  localparam logic [3:0] REG_NONE = 4'hF;

  // fn 0 is "always" so RRMOV/JMP share the table with CMOVxx/Jxx
  function automatic logic cond_holds(input logic [3:0] fn, input logic [2:0] f);
    logic lt;
    logic zf;
    lt = f[CC_SF] ^ f[CC_OF];
    zf = f[CC_ZF];
    case (fn)
      4'd0:    cond_holds = 1'b1;
      4'd1:    cond_holds = lt | zf;
      4'd2:    cond_holds = lt;
      4'd3:    cond_holds = zf;
      4'd4:    cond_holds = ~zf;
      4'd5:    cond_holds = ~lt;
      4'd6:    cond_holds = ~lt & ~zf;
      default: cond_holds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipez_alu.sv
// Combinational 32-bit ALU producing result and {ZF,SF,OF}.
module pipez_alu
  import pipez_pkg::*;
(
  input  alu_fun_e    fun,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  always_comb begin
    result = '0;
    flags  = '0;
    case (fun)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
    flags[CC_ZF] = (result == '0);
    flags[CC_SF] = result[31];
    case (fun)
      ALU_ADD: flags[CC_OF] = (a[31] == b[31]) && (result[31] != a[31]);
      ALU_SUB: flags[CC_OF] = (a[31] != b[31]) && (result[31] != a[31]);
      default: flags[CC_OF] = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipez_ram.sv
// Single-port instruction RAM: synchronous write, registered read with read enable.
module pipez_ram #(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/pipez_regfile.sv
// Eight 32-bit registers, async reset to zero, one synchronous write port.
module pipez_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] regs [8]
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/pipez_core.sv
// 4-stage (Fetch/Decode/Execute/Write-back) pipelined core with host load port,
// full forwarding, 1-bubble taken jumps and HALT.
module pipez_core
  import pipez_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic        working,
  input  logic [3:0]  rID,
  output logic [31:0] valE,
  output logic [31:0] r0,
  output logic [31:0] r1,
  output logic [31:0] r2,
  output logic [31:0] r3,
  output logic [31:0] r4,
  output logic [31:0] r5,
  output logic [31:0] r6,
  output logic [31:0] r7,
  output logic [31:0] rdata,
  output logic [2:0]  cc
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [AW-1:0] pc;
  logic          d_valid;
  logic [31:0]   instr;
  run_state_e    state, state_next;

  logic          e_we, e_setcc;
  logic [2:0]    e_dst;
  alu_fun_e      e_fun;
  logic [31:0]   e_a, e_b;

  logic          w_we;
  logic [2:0]    w_dst;
  logic [31:0]   w_val;

  logic [2:0]    cc_q;
  logic [31:0]   alu_res;
  logic [2:0]    alu_flags;
  logic [31:0]   rf [8];

  logic          n_we, n_setcc;
  logic [2:0]    n_dst;
  alu_fun_e      n_fun;
  logic [31:0]   n_a, n_b;
  logic          take_jump, halt_dec;

  logic [7:0]    op;
  logic [3:0]    ra, rb;
  logic [31:0]   va, vb;
  logic [2:0]    flags_d;
  logic          cond;

  logic [AW-1:0] ram_addr;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^addr[31:AW];
  assign ram_addr = working ? pc : addr[AW-1:0];

  pipez_ram #(.DEPTH(MEM_DEPTH)) u_ram (
    .clock (clock),
    .we    (wr & ~working),
    .re    (working),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (instr)
  );

  pipez_alu u_alu (
    .fun    (e_fun),
    .a      (e_a),
    .b      (e_b),
    .result (alu_res),
    .flags  (alu_flags)
  );

  pipez_regfile u_rf (
    .clock (clock),
    .reset (reset),
    .we    (w_we & working),
    .waddr (w_dst),
    .wdata (w_val),
    .regs  (rf)
  );

  function automatic logic [31:0] fwd(input logic [3:0] id);
    if (id[3]) return '0;
    if (e_we && e_dst == id[2:0]) return alu_res;
    if (w_we && w_dst == id[2:0]) return w_val;
    return rf[id[2:0]];
  endfunction

  assign op = instr[31:24];
  assign ra = instr[23:20];
  assign rb = instr[19:16];
  assign va = fwd(ra);
  assign vb = fwd(rb);
  // An OP sitting in Execute hasn't committed its flags yet, so take them from the ALU
  assign flags_d = e_setcc ? alu_flags : cc_q;
  assign cond = cond_holds(instr[27:24], flags_d);

  always_comb begin
    n_we      = 1'b0;
    n_setcc   = 1'b0;
    n_dst     = '0;
    n_fun     = ALU_ADD;
    n_a       = '0;
    n_b       = '0;
    take_jump = 1'b0;
    halt_dec  = 1'b0;
    if (d_valid && state == ST_RUN) begin
      case (op) inside
        OP_IRMOV: begin
          n_we  = (rb != REG_NONE) && !rb[3];
          n_dst = rb[2:0];
          n_a   = {16'h0000, instr[15:0]};
        end
        OP_HALT: halt_dec = 1'b1;
        [OP_ADD:OP_XOR]: begin
          n_we    = !ra[3];
          n_dst   = ra[2:0];
          n_fun   = alu_fun_e'(instr[25:24]);
          n_a     = va;
          n_b     = vb;
          n_setcc = 1'b1;
        end
        [OP_RRMOV:OP_CMOVG]: begin
          n_we  = !ra[3] && cond;
          n_dst = ra[2:0];
          n_a   = vb;
        end
        [OP_JMP:OP_JG]: take_jump = cond;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    if (halt_dec) state_next = ST_HALT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_RUN;
    else if (working) state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      d_valid <= 1'b0;
      e_we    <= 1'b0;
      e_setcc <= 1'b0;
      e_dst   <= '0;
      e_fun   <= ALU_ADD;
      e_a     <= '0;
      e_b     <= '0;
      w_we    <= 1'b0;
      w_dst   <= '0;
      w_val   <= '0;
      cc_q    <= '0;
    end else if (working) begin
      if (take_jump) pc <= instr[AW-1:0];
      else if (!halt_dec && state == ST_RUN) pc <= pc + AW'(1);
      d_valid <= ~take_jump;
      e_we    <= n_we;
      e_setcc <= n_setcc;
      e_dst   <= n_dst;
      e_fun   <= n_fun;
      e_a     <= n_a;
      e_b     <= n_b;
      w_we    <= e_we;
      w_dst   <= e_dst;
      w_val   <= alu_res;
      if (e_setcc) cc_q <= alu_flags;
    end
  end

  assign valE  = alu_res;
  assign cc    = cc_q;
  assign rdata = rID[3] ? '0 : rf[rID[2:0]];
  assign r0 = rf[0];
  assign r1 = rf[1];
  assign r2 = rf[2];
  assign r3 = rf[3];
  assign r4 = rf[4];
  assign r5 = rf[5];
  assign r6 = rf[6];
  assign r7 = rf[7];

endmodule

// File: tb/tb_pipez_core.sv
// Directed table-driven bench for pipez_core: loads small programs, runs them and
// compares registers, rdata and cc against hand-computed values.
module tb_pipez_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  = '0;
  logic        wr    = 1'b0;
  logic [31:0] wdata = '0;
  logic        working = 1'b0;
  logic [3:0]  rID   = '0;
  logic [31:0] valE, rdata;
  logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [2:0]  cc;

  int unsigned passed = 0;
  int unsigned total  = 0;

  typedef struct {
    string       name;
    logic [3:0]  rid;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [$];
  logic [31:0] prog [16];
  int unsigned prog_len;

  pipez_core #(.MEM_DEPTH(256)) dut (
    .clock   (clock),
    .reset   (reset),
    .addr    (addr),
    .wr      (wr),
    .wdata   (wdata),
    .working (working),
    .rID     (rID),
    .valE    (valE),
    .r0      (r0),
    .r1      (r1),
    .r2      (r2),
    .r3      (r3),
    .r4      (r4),
    .r5      (r5),
    .r6      (r6),
    .r7      (r7),
    .rdata   (rdata),
    .cc      (cc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] irmov(input logic [3:0] rb, input logic [15:0] v);
    return {8'h10, 4'hF, rb, v};
  endfunction

  function automatic logic [31:0] opr(input logic [7:0] opc, input logic [3:0] ra, input logic [3:0] rb);
    return {opc, ra, rb, 16'h0000};
  endfunction

  function automatic logic [31:0] jmp(input logic [3:0] fn, input logic [23:0] t);
    return {4'h7, fn, t};
  endfunction

  function automatic logic [31:0] rport(input int unsigned i);
    case (i)
      0: return r0;
      1: return r1;
      2: return r2;
      3: return r3;
      4: return r4;
      5: return r5;
      6: return r6;
      default: return r7;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    working = 1'b0;
    wr = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic load_prog();
    for (int unsigned i = 0; i < prog_len; i++) begin
      @(negedge clock);
      addr  = i;
      wdata = prog[i];
      wr    = 1'b1;
    end
    @(negedge clock);
    wr = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clock);
    working = 1'b1;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_vecs();
    foreach (vecs[i]) begin
      rID = vecs[i].rid;
      #1;
      check({vecs[i].name, "/rdata"}, rdata, vecs[i].exp);
      if (!vecs[i].rid[3]) check({vecs[i].name, "/port"}, rport(vecs[i].rid), vecs[i].exp);
    end
    vecs.delete();
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    for (int unsigned i = 0; i < 8; i++) vecs.push_back('{$sformatf("rst_r%0d", i), 4'(i), 32'h0});
    apply_vecs();
    check("rst_cc", {29'h0, cc}, 32'h0);
    check("rst_valE", valE, 32'h0);

    // IRMOV r0..r7 = 1..8, JMP over a squashed ADD, then ADD r0,r0
    for (int unsigned i = 0; i < 8; i++) prog[i] = irmov(4'(i), 16'(i + 1));
    prog[8]  = jmp(4'h0, 24'h00000A);
    prog[9]  = opr(8'h20, 4'h7, 4'h6);
    prog[10] = opr(8'h20, 4'h0, 4'h0);
    prog[11] = 32'h11000000;
    prog_len = 12;
    load_prog();
    start_run();
    run(30);
    vecs.push_back('{"p1_r0", 4'd0, 32'd2});
    for (int unsigned i = 1; i < 8; i++) vecs.push_back('{$sformatf("p1_r%0d", i), 4'(i), 32'(i + 1)});
    vecs.push_back('{"p1_rid8", 4'd8, 32'h0});
    vecs.push_back('{"p1_ridF", 4'hF, 32'h0});
    apply_vecs();

    // Back-to-back dependency, cycle-exact
    do_reset();
    prog[0] = irmov(4'h1, 16'd5);
    prog[1] = irmov(4'h2, 16'd3);
    prog[2] = opr(8'h21, 4'h1, 4'h2);
    prog[3] = opr(8'h20, 4'h1, 4'h1);
    prog[4] = 32'h11000000;
    prog_len = 5;
    load_prog();
    start_run();
    run(5);
    check("dep_cc_after_sub", {29'h0, cc}, 32'h0);
    run(1);
    check("dep_r1_sub", r1, 32'd2);
    run(1);
    check("dep_r1_add", r1, 32'd4);
    check("dep_r2", r2, 32'd3);

    // Countdown loop with a pause mid-run
    do_reset();
    prog[0] = irmov(4'h0, 16'd1);
    prog[1] = irmov(4'h7, 16'd3);
    prog[2] = opr(8'h21, 4'h7, 4'h0);
    prog[3] = jmp(4'h5, 24'h000002);
    prog[4] = 32'h11000000;
    prog_len = 5;
    load_prog();
    start_run();
    run(8);
    @(negedge clock);
    working = 1'b0;
    addr = 32'h40;
    wdata = 32'hDEADBEEF;
    wr = 1'b1;
    run(4);
    @(negedge clock);
    wr = 1'b0;
    working = 1'b1;
    run(40);
    check("loop_r7", r7, 32'hFFFFFFFF);
    check("loop_r0", r0, 32'd1);
    check("loop_cc", {29'h0, cc}, 32'h2);

    // CMOV using forwarded flags and committed cc
    do_reset();
    prog[0] = irmov(4'h1, 16'd1);
    prog[1] = irmov(4'h2, 16'd2);
    prog[2] = opr(8'h21, 4'h1, 4'h1);
    prog[3] = opr(8'h33, 4'h3, 4'h2);
    prog[4] = opr(8'h34, 4'h4, 4'h2);
    prog[5] = 32'h11000000;
    prog_len = 6;
    load_prog();
    start_run();
    run(20);
    check("cmove_r3", r3, 32'd2);
    check("cmovne_r4", r4, 32'd0);
    check("cmov_cc", {29'h0, cc}, 32'h4);

    // HALT, ignored host write while running, then async reset mid-run
    do_reset();
    prog[0] = irmov(4'h1, 16'd7);
    prog[1] = opr(8'h21, 4'h2, 4'h2);
    prog[2] = 32'h11000000;
    prog[3] = irmov(4'h5, 16'd9);
    prog_len = 4;
    load_prog();
    start_run();
    run(20);
    check("halt_r5", r5, 32'd0);
    check("halt_r1", r1, 32'd7);
    check("halt_cc", {29'h0, cc}, 32'h4);
    @(negedge clock);
    addr = 32'h0;
    wdata = irmov(4'h1, 16'h63);
    wr = 1'b1;
    run(2);
    @(negedge clock);
    wr = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    for (int unsigned i = 0; i < 8; i++) vecs.push_back('{$sformatf("mid_rst_r%0d", i), 4'(i), 32'h0});
    apply_vecs();
    check("mid_rst_cc", {29'h0, cc}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    run(20);
    check("rerun_r1", r1, 32'd7);
    check("rerun_r5", r5, 32'd0);
    check("rerun_cc", {29'h0, cc}, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
